// File: rtl/mpp_control_unit.sv
// rtl/mpp_control_unit.sv - fetch/decode/execute/writeback sequencer for the 8-bit mpp datapath.
// Optional single-step gating of FETCH is enabled with MPP_CTRL_SINGLE_STEP_EN.
module mpp_control_unit #(
   parameter int                  PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [PC_WIDTH-1:0] imem_addr,
   output logic                imem_rd,
   input  logic [15:0]         imem_data,
   output logic [2:0]          alu_sel,
   output logic                alu_en,
   output logic                alu_b_imm,
   output logic [7:0]          imm,
   output logic [1:0]          rd_addr,
   output logic [1:0]          rs_addr,
   output logic                reg_we,
   input  logic [7:0]          alu_out,
   input  logic                alu_carry,
   output logic                flag_z,
   output logic                flag_c,
`ifdef MPP_CTRL_SINGLE_STEP_EN
   input  logic                step,
   output logic                step_wait,
`endif
   output logic                halted
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_WRITEBACK = 3'd3,
      S_HALT      = 3'd4
   } state_t;

   state_t              state, state_next;
   logic [PC_WIDTH-1:0] pc;
   logic [15:0]         ir;
   logic                started;
   logic                fz, fc;

   logic [3:0] op;
   logic       is_ldi, is_alu, is_halt, keeps_c, take_branch, go;

   assign op      = ir[15:12];
   assign is_ldi  = (op == 4'h8);
   assign is_alu  = ~op[3] | is_ldi;
   assign is_halt = (op == 4'hC);
   // Logic ops and LDI leave carry alone; only add/sub/op7 produce a carry.
   assign keeps_c = ((op >= 4'h2) && (op <= 4'h6)) | is_ldi;

   assign take_branch = (op == 4'h9)
                      | ((op == 4'hA) & fz)
                      | ((op == 4'hB) & fc);

   assign imem_addr = pc;
   assign rd_addr   = ir[11:10];
   assign rs_addr   = ir[9:8];
   assign imm       = ir[7:0];
   assign alu_b_imm = is_ldi;
   assign alu_sel   = op[3] ? (is_ldi ? 3'b110 : 3'b000) : op[2:0];
   assign flag_z    = fz;
   assign flag_c    = fc;

   // The first cycle out of reset only arms the fetch so imem_rd is low during reset.
`ifdef MPP_CTRL_SINGLE_STEP_EN
   assign go = started & step;
`else
   assign go = started;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         pc      <= RESET_PC;
         ir      <= '0;
         started <= 1'b0;
         fz      <= 1'b1;
         fc      <= 1'b0;
      end else begin
         state   <= state_next;
         started <= 1'b1;
         if (state == S_DECODE) begin
            ir <= imem_data;
            pc <= pc + PC_WIDTH'(1);
         end
         if ((state == S_EXECUTE) && take_branch) begin
            pc <= PC_WIDTH'(ir[7:0]);
         end
         if (state == S_WRITEBACK) begin
            fz <= (alu_out == 8'h00);
            if (!keeps_c) begin
               fc <= alu_carry;
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      imem_rd    = 1'b0;
      alu_en     = 1'b0;
      reg_we     = 1'b0;
      halted     = 1'b0;
`ifdef MPP_CTRL_SINGLE_STEP_EN
      step_wait  = 1'b0;
`endif
      unique case (state)
         S_FETCH: begin
            if (go) begin
               imem_rd    = 1'b1;
               state_next = S_DECODE;
            end
`ifdef MPP_CTRL_SINGLE_STEP_EN
            step_wait = ~go;
`endif
         end
         S_DECODE: begin
            state_next = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (is_alu) begin
               alu_en     = 1'b1;
               state_next = S_WRITEBACK;
            end else if (is_halt) begin
               state_next = S_HALT;
            end else begin
               state_next = S_FETCH;
            end
         end
         S_WRITEBACK: begin
            alu_en     = 1'b1;
            reg_we     = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_next = S_FETCH;
         end
      endcase
   end

endmodule
